sr_cmd_gen: RTL and testbench
=============================

Name: sr_cmd_gen

Overview:
Command front-end that sits directly upstream of the SR flip-flop and drives its s/r inputs. Takes two raw, possibly bouncy, asynchronous request lines (set_in, clr_in), synchronises and debounces them, and detects rising edges. It arbitrates simultaneous requests and issues single-cycle s or r pulses spaced by a guard interval. s and r are never high together, so the flip-flop's invalid s=1/r=1 input is unreachable.

Parameters:
DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=2)
GUARD_CYCLES, 3, idle cycles enforced after every issued pulse (>=1)
RST_PRIORITY, 1, 1: clear wins when set and clear requests are both pending; 0: set wins

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
set_in  input  1  raw set request, asynchronous to clk
clr_in  input  1  raw clear request, asynchronous to clk
s  output  1  registered one-cycle set pulse to flip-flop
r  output  1  registered one-cycle reset pulse to flip-flop
busy  output  1  high in PULSE and GUARD states
conflict  output  1  one-cycle pulse, coincident with s/r, when both requests were pending and one was dropped

Behaviour:
- Reset (rst=0, asynchronous): synchronisers, debounced levels, counters, pending flags cleared to 0; FSM to IDLE; s=r=busy=conflict=0. Outputs stay 0 until the first rising clk after rst returns to 1.
- Synchroniser: two-flop chain per input. No logic on the first stage.
- Debounce, per channel:
  - Counter width = clog2(DB_CYCLES)+1.
  - Synced value equal to the debounced level: counter clears to 0.
  - Differing: counter increments.
  - Debounced level toggles and counter clears on the edge where the counter would reach DB_CYCLES.
  - Any glitch shorter than DB_CYCLES synced cycles is absorbed.
- Edge detect: only a 0->1 transition of a debounced level raises its pending flag (set_pend/clr_pend). Falling edges are ignored. A pending flag already set stays set; requests do not queue.
- Pending flags are captured in every FSM state, including PULSE and GUARD.
- FSM:
  - IDLE: if any pending flag is set, go to PULSE. Choose the winner by pending flags: if only one is set, that one; if both, RST_PRIORITY decides.
  - PULSE: exactly one cycle; s or r = 1 for the winner. The winner's pending flag clears. If both were pending, the loser's flag also clears and conflict=1 this cycle. Go to GUARD.
  - GUARD: guard counter runs GUARD_CYCLES cycles with s=r=0, then go to IDLE.
- Latency: set_in rising, sampled high at edge E0 and held clean → debounced level rises at edge E0+DB_CYCLES+1 → s high from edge E0+DB_CYCLES+2 for one cycle (E0+6 with defaults), if the FSM is in IDLE.
- Throughput: at most one pulse every GUARD_CYCLES+1 cycles.
- Invariant: s & r == 0 in every cycle. conflict implies (s|r).
- A request arriving in GUARD is served on the first IDLE cycle, with no extra idle cycle.
- Reset mid-PULSE or mid-GUARD: pulse aborts immediately (s/r to 0 asynchronously); pending requests are lost.
- A held input produces exactly one pulse. A new pulse requires release longer than DB_CYCLES, then a re-press.

Test Plan:
- Reset: rst=0 with set_in=clr_in=1 → s=r=busy=conflict=0; release rst at edge 0 with both inputs held high → exactly one r pulse at edge 6 with conflict=1, then nothing further.
- Clean set: set_in 0→1 at E0, held 20 cycles → s=1 only in cycle E0+6→E0+7; busy high for cycles 6..9; r never asserts.
- Bounce: clr_in toggles 1,0,1,0 each cycle for 6 cycles, then stays 1 → single r pulse 6 cycles after the final rising sample; no pulse during bouncing. A 3-cycle glitch alone produces no pulse.
- Simultaneous requests: set_in and clr_in rise on the same edge, RST_PRIORITY=1 → r pulse with conflict=1, s never asserts. Repeat with RST_PRIORITY=0 → s pulse with conflict=1.
- Request during GUARD: clr_in rises so clr_pend is set 1 cycle after an s pulse → r issued on cycle s+4 (GUARD_CYCLES=3); s&r==0 checked every cycle.
- Reset mid-operation: assert rst=0 in the PULSE cycle → s drops before the next edge; after release, no pulse without a new rising input.

Source files
------------

// File: rtl/sr_cmd_gen_if.sv
// Request/command bundle between the raw request lines,
// the command generator and the SR flip-flop it drives.
interface sr_cmd_gen_if;
    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_in, clr_in,
        input  s, r, busy, conflict
    );

    modport slave (
        input  set_in, clr_in,
        output s, r, busy, conflict
    );
endinterface

// File: rtl/sr_cmd_gen.sv
// SR flip-flop command front-end: sync, debounce, edge detect,
// arbitrate and issue guarded one-cycle s/r pulses.
module sr_cmd_gen #(
    parameter int unsigned DB_CYCLES    = 4,
    parameter int unsigned GUARD_CYCLES = 3,
    parameter bit          RST_PRIORITY = 1'b1
) (
    input logic         clk,
    input logic         rst,
    sr_cmd_gen_if.slave bus
);
    localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GUARD
    } state_e;

    // Channel index 0 is set, 1 is clear.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         lvl_q, lvl_d, rise;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         pend_q, pend_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    state_e             state_q, state_d;
    logic               s_q, s_d, r_q, r_d, cf_q, cf_d;
    logic               issue, take_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.clr_in, bus.set_in};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                lvl_d[i] = ~lvl_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign rise = lvl_d & ~lvl_q;

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        cf_d    = 1'b0;
        issue   = 1'b0;
        take_r  = 1'b0;
        unique case (state_q)
            IDLE: issue = |pend_q;
            PULSE: begin
                state_d = GUARD;
                gcnt_d  = '0;
            end
            GUARD: begin
                // Last guard cycle may launch the next pulse directly.
                if (gcnt_q == G_LAST) begin
                    state_d = IDLE;
                    issue   = |pend_q;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d = PULSE;
            take_r  = pend_q[1] & (~pend_q[0] | RST_PRIORITY);
            s_d     = ~take_r;
            r_d     = take_r;
            cf_d    = &pend_q;
        end
        pend_d = (issue ? 2'b00 : pend_q) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            gcnt_q  <= '0;
            state_q <= IDLE;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gcnt_q  <= gcnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            r_q     <= r_d;
            cf_q    <= cf_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.conflict = cf_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: timeline model of debounce/arbitration
// plus directed literal checks, then random request traffic.
module tb_sr_cmd_gen;
    localparam int DB = 4;
    localparam int G  = 3;

    logic clk;
    logic rst;
    logic set_in;
    logic clr_in;

    sr_cmd_gen_if if0 ();
    sr_cmd_gen_if if1 ();

    assign if0.set_in = set_in;
    assign if0.clr_in = clr_in;
    assign if1.set_in = set_in;
    assign if1.clr_in = clr_in;

    sr_cmd_gen #(
        .DB_CYCLES   (DB),
        .GUARD_CYCLES(G),
        .RST_PRIORITY(1'b1)
    ) u0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    sr_cmd_gen #(
        .DB_CYCLES   (DB),
        .GUARD_CYCLES(G),
        .RST_PRIORITY(1'b0)
    ) u1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;
    int n_edge;
    int scnt;
    int rcnt;

    // Model: sample history, debounced levels, and per-instance
    // pending flags plus the edge of the last issued pulse.
    bit [DB+1:0] hs, hc;
    bit          lvl_s, lvl_c;
    bit [1:0]    pend[2];
    int          last[2];
    bit          es[2], er[2], eb[2], ec[2];

    task automatic model_reset();
        hs = '0;
        hc = '0;
        lvl_s = 1'b0;
        lvl_c = 1'b0;
        n_edge = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 2'b00;
            last[p] = -100;
            es[p] = 1'b0;
            er[p] = 1'b0;
            eb[p] = 1'b0;
            ec[p] = 1'b0;
        end
    endtask

    function automatic bit all_differ(bit [DB-1:0] w, bit lvl);
        return lvl ? (w == '0) : (&w);
    endfunction

    task automatic chk(string name, logic got, logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %b want %b",
                     name, $time, got, want);
        end
    endtask

    task automatic cmp_dut(int id, logic s, logic r,
                           logic b, logic c);
        n_vec++;
        if ({s, r, b, c} !== {es[id], er[id], eb[id], ec[id]} ||
            (s & r) !== 1'b0) begin
            n_bad++;
            $display("FAIL dut%0d t=%0t s/r/busy/conf got %b%b%b%b want %b%b%b%b",
                     id, $time, s, r, b, c,
                     es[id], er[id], eb[id], ec[id]);
        end
    endtask

    task automatic step();
        bit fs, fc, rs, rc, go, both, rwin;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            n_edge++;
            hs = {hs[DB:0], set_in};
            hc = {hc[DB:0], clr_in};
            fs = all_differ(hs[DB+1:2], lvl_s);
            fc = all_differ(hc[DB+1:2], lvl_c);
            rs = fs & ~lvl_s;
            rc = fc & ~lvl_c;
            lvl_s = lvl_s ^ fs;
            lvl_c = lvl_c ^ fc;
            for (int p = 0; p < 2; p++) begin
                go = (pend[p] != 2'b00) && (n_edge - last[p] > G);
                es[p] = 1'b0;
                er[p] = 1'b0;
                ec[p] = 1'b0;
                if (go) begin
                    both = &pend[p];
                    rwin = pend[p][1] && (!pend[p][0] || p == 0);
                    er[p] = rwin;
                    es[p] = !rwin;
                    ec[p] = both;
                    last[p] = n_edge;
                    pend[p] = 2'b00;
                end
                pend[p] = pend[p] | {rc, rs};
                eb[p] = (n_edge - last[p] <= G);
            end
        end
        #1;
        cmp_dut(0, if0.s, if0.r, if0.busy, if0.conflict);
        cmp_dut(1, if1.s, if1.r, if1.busy, if1.conflict);
        scnt += int'(if0.s);
        rcnt += int'(if0.r);
    endtask

    task automatic quiesce();
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (15) step();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        scnt = 0;
        rcnt = 0;
        rst = 1'b0;
        set_in = 1'b1;
        clr_in = 1'b1;
        model_reset();
        #2;
        chk("rst_s", if0.s, 1'b0);
        chk("rst_r", if0.r, 1'b0);
        chk("rst_busy", if0.busy, 1'b0);
        chk("rst_conf", if0.conflict, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("rel_r", if0.r, k == 7);
            chk("rel_conf", if0.conflict, k == 7);
            chk("rel_s_p1", if0.s, 1'b0);
            chk("rel_s_p0", if1.s, k == 7);
        end
        quiesce();

        set_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("set_s", if0.s, k == 7);
            chk("set_busy", if0.busy, k >= 7 && k <= 10);
            chk("set_r", if0.r, 1'b0);
        end
        quiesce();

        for (int i = 0; i < 6; i++) begin
            clr_in = (i % 2 == 0);
            step();
            chk("bounce_quiet", if0.r, 1'b0);
        end
        clr_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("bounce_r", if0.r, k == 7);
        end
        quiesce();

        rcnt = 0;
        clr_in = 1'b1;
        repeat (3) step();
        clr_in = 1'b0;
        repeat (12) step();
        chk("glitch_none", rcnt != 0, 1'b0);
        quiesce();

        set_in = 1'b1;
        clr_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("sim_r_p1", if0.r, k == 7);
            chk("sim_cf_p1", if0.conflict, k == 7);
            chk("sim_s_p0", if1.s, k == 7);
            chk("sim_cf_p0", if1.conflict, k == 7);
        end
        quiesce();

        set_in = 1'b1;
        step();
        step();
        clr_in = 1'b1;
        for (int k = 3; k <= 14; k++) begin
            step();
            chk("guard_s", if0.s, k == 7);
            chk("guard_r", if0.r, k == 11);
            chk("guard_cf", if0.conflict, 1'b0);
        end
        quiesce();

        set_in = 1'b1;
        repeat (7) step();
        chk("mid_pulse_s", if0.s, 1'b1);
        set_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_abort_s", if0.s, 1'b0);
        chk("mid_abort_busy", if0.busy, 1'b0);
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        scnt = 0;
        rcnt = 0;
        repeat (20) step();
        chk("mid_no_s", scnt != 0, 1'b0);
        chk("mid_no_r", rcnt != 0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) set_in = ~set_in;
            if ($urandom_range(5) == 0) clr_in = ~clr_in;
            if ($urandom_range(299) == 0) begin
                rst = 1'b0;
                repeat (2) step();
                rst = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
